// File: rtl/ram_2w1r_if.sv
// rtl/ram_2w1r_if.sv - write/read port bundle for the dual-write single-read RAM
interface ram_2w1r_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              en;
  logic              wr_en1;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data1;
  logic              wr_en2;
  logic [ADDR_W-1:0] wr_addr2;
  logic [DATA_W-1:0] wr_data2;
  logic              wr_rdy2;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        pend_cnt;
  logic              collision;

  modport master (
    output en, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2, rd_addr,
    input  wr_rdy2, rd_data, pend_cnt, collision
  );

  modport slave (
    input  en, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2, rd_addr,
    output wr_rdy2, rd_data, pend_cnt, collision
  );
endinterface

// File: rtl/ram_2w1r.sv
// rtl/ram_2w1r.sv - 64x8 RAM, two write ports onto one array write port, port 2 via pending buffer
module ram_2w1r #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int PEND_DEPTH = 2
) (
  input logic      clk,
  input logic      rst,
  ram_2w1r_if.slave bus
);
  localparam logic [1:0] PEND_FULL = 2'(PEND_DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Pending queue is a shift register: entry 0 is the head (oldest).
  logic [ADDR_W-1:0]     p_addr [PEND_DEPTH];
  logic [DATA_W-1:0]     p_data [PEND_DEPTH];
  logic [PEND_DEPTH-1:0] p_kill;
  logic [1:0]            cnt;

  logic [ADDR_W-1:0]     n_addr [PEND_DEPTH];
  logic [DATA_W-1:0]     n_data [PEND_DEPTH];
  logic [PEND_DEPTH-1:0] n_kill;
  logic [1:0]            n_cnt;

  logic acc1, acc2, coll, pop, direct, push, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_next;
  int                push_idx;

  assign bus.wr_rdy2  = bus.en && !rst && (cnt != PEND_FULL);
  assign bus.pend_cnt = cnt;

  always_comb begin
    acc1     = bus.en && !rst && bus.wr_en1;
    acc2     = bus.wr_en2 && bus.wr_rdy2;
    coll     = acc1 && acc2 && (bus.wr_addr1 == bus.wr_addr2);
    pop      = bus.en && !rst && !bus.wr_en1 && (cnt != 2'd0);
    direct   = acc2 && !bus.wr_en1 && (cnt == 2'd0);
    push     = acc2 && !coll && !direct;
    push_idx = int'(cnt) - (pop ? 1 : 0);

    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr1;
    mem_wdata = bus.wr_data1;
    if (acc1) begin
      mem_we = 1'b1;
    end else if (pop) begin
      // A killed head still consumes the slot but leaves the array alone.
      mem_we    = !p_kill[0];
      mem_waddr = p_addr[0];
      mem_wdata = p_data[0];
    end else if (direct) begin
      mem_we    = 1'b1;
      mem_waddr = bus.wr_addr2;
      mem_wdata = bus.wr_data2;
    end

    for (int i = 0; i < PEND_DEPTH; i++) begin
      n_addr[i] = p_addr[i];
      n_data[i] = p_data[i];
      n_kill[i] = p_kill[i] | (acc1 && (p_addr[i] == bus.wr_addr1));
    end
    if (pop) begin
      for (int i = 0; i < PEND_DEPTH - 1; i++) begin
        n_addr[i] = n_addr[i+1];
        n_data[i] = n_data[i+1];
        n_kill[i] = n_kill[i+1];
      end
      n_kill[PEND_DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < PEND_DEPTH; i++) begin
        if (i == push_idx) begin
          n_addr[i] = bus.wr_addr2;
          n_data[i] = bus.wr_data2;
          n_kill[i] = 1'b0;
        end
      end
    end
    n_cnt = cnt - {1'b0, pop} + {1'b0, push};

    // Later entries are newer, so the last match wins.
    rd_next = mem[bus.rd_addr];
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if ((int'(cnt) > i) && !p_kill[i] && (p_addr[i] == bus.rd_addr)) begin
        rd_next = p_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 2'd0;
      p_kill        <= '0;
      bus.rd_data   <= '0;
      bus.collision <= 1'b0;
      for (int i = 0; i < PEND_DEPTH; i++) begin
        p_addr[i] <= '0;
        p_data[i] <= '0;
      end
    end else if (bus.en) begin
      cnt           <= n_cnt;
      p_kill        <= n_kill;
      bus.rd_data   <= rd_next;
      bus.collision <= coll;
      for (int i = 0; i < PEND_DEPTH; i++) begin
        p_addr[i] <= n_addr[i];
        p_data[i] <= n_data[i];
      end
    end else begin
      bus.collision <= 1'b0;
    end
  end
endmodule
